time_set_ctrl: RTL and testbench

Consumer of the key_press_short / key_press_long single-cycle pulses from the button front end in the digital clock. It keeps hours/minutes/seconds time, advanced by a 1 Hz tick, and runs the time-setting state machine: long press walks the modes, short press increments the selected field. It drives the display mux and the blink control.

---
 rtl/clock_pkg.sv | 16 +
 rtl/mod_counter.sv | 35 +++
 rtl/time_set_ctrl.sv | 138 +++++++++++++
 tb/tb_time_set_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock time-keeping and time-setting logic.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam int HOUR_W        = 5;
    localparam int MIN_W         = 6;
    localparam int HOUR_MAX_DEF  = 23;
    localparam int MIN_MAX_DEF   = 59;
    localparam int TIMEOUT_S_DEF = 30;

endpackage

// File: rtl/mod_counter.sv
// Modulo counter with explicit compare-to-max wrap and a same-cycle carry for chaining.
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry_out
);

    logic [W-1:0] value_r;
    logic         at_max_s;

    // >= keeps the field inside 0..MAX even if it were ever pushed past the top
    assign at_max_s  = (value_r >= W'(MAX));
    assign carry_out = inc & at_max_s;
    assign value     = value_r;

    // Field register: clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= '0;
        end else if (clr) begin
            value_r <= '0;
        end else if (inc) begin
            value_r <= at_max_s ? '0 : (value_r + W'(1));
        end else begin
            value_r <= value_r;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-keeping plus long/short-press time-setting FSM and blink control.
// Optional build macro SET_TIMEOUT_EN: idle set modes fall back to RUN after TIMEOUT_S ticks.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOUR_MAX  = HOUR_MAX_DEF,
    parameter int MIN_MAX   = MIN_MAX_DEF,
    parameter int TIMEOUT_S = TIMEOUT_S_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic              key_press_short,
    input  logic              key_press_long,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [MIN_W-1:0]  seconds,
    output logic [1:0]        mode,
    output logic              blink_on
);

    mode_t mode_r, mode_nxt_s;
    logic  blink_r, blink_nxt_s;
    logic  short_s, key_any_s;
    logic  run_s, set_hour_s, set_min_s;
    logic  sec_inc_s, min_inc_s, hr_inc_s, sec_clr_s;
    logic  sec_carry_s, min_carry_s, hr_carry_s;

    // Long press always wins, so a coincident short press is dropped
    assign short_s    = key_press_short & ~key_press_long;
    assign key_any_s  = key_press_short | key_press_long;
    assign run_s      = (mode_r == RUN);
    assign set_hour_s = (mode_r == SET_HOUR);
    assign set_min_s  = (mode_r == SET_MIN);

    // Carries only chain in RUN; set modes edit one field with no carry
    assign sec_inc_s  = run_s & tick_1hz;
    assign min_inc_s  = run_s ? sec_carry_s : (set_min_s & short_s);
    assign hr_inc_s   = run_s ? min_carry_s : (set_hour_s & short_s);
    assign sec_clr_s  = set_min_s & key_press_long;

    mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_inc_s), .clr(sec_clr_s),
        .value(seconds), .carry_out(sec_carry_s)
    );

    mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .inc(min_inc_s), .clr(1'b0),
        .value(minutes), .carry_out(min_carry_s)
    );

    mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .inc(hr_inc_s), .clr(1'b0),
        .value(hours), .carry_out(hr_carry_s)
    );

`ifdef SET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_S + 1);
    logic [TO_W-1:0] to_r, to_nxt_s;
`endif

    // Mode / blink next-state: key pulses first, then tick-driven blink and timeout
    always_comb begin
        mode_nxt_s  = mode_r;
        blink_nxt_s = blink_r;
`ifdef SET_TIMEOUT_EN
        to_nxt_s    = to_r;
`endif
        case (mode_r)
            RUN: begin
                blink_nxt_s = 1'b1;
                if (key_press_long) begin
                    mode_nxt_s = SET_HOUR;
                end else begin
                    mode_nxt_s = RUN;
                end
            end
            SET_HOUR, SET_MIN: begin
                if (key_press_long) begin
                    mode_nxt_s  = set_hour_s ? SET_MIN : RUN;
                    blink_nxt_s = 1'b1;
                end else if (short_s) begin
                    blink_nxt_s = 1'b1;
                end else if (tick_1hz) begin
                    blink_nxt_s = ~blink_r;
                end else begin
                    blink_nxt_s = blink_r;
                end
            end
            default: begin
                mode_nxt_s  = RUN;
                blink_nxt_s = 1'b1;
            end
        endcase
`ifdef SET_TIMEOUT_EN
        // A key pulse restarts the idle count and beats a coincident timeout
        if (run_s || key_any_s) begin
            to_nxt_s = '0;
        end else if (tick_1hz) begin
            if (to_r >= TO_W'(TIMEOUT_S - 1)) begin
                to_nxt_s    = '0;
                mode_nxt_s  = RUN;
                blink_nxt_s = 1'b1;
            end else begin
                to_nxt_s = to_r + TO_W'(1);
            end
        end else begin
            to_nxt_s = to_r;
        end
`endif
    end

    // Registered FSM state and blink enable
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r  <= RUN;
            blink_r <= 1'b1;
        end else begin
            mode_r  <= mode_nxt_s;
            blink_r <= blink_nxt_s;
        end
    end

`ifdef SET_TIMEOUT_EN
    // Idle-tick counter for the set-mode auto exit
    always_ff @(posedge clk) begin
        if (rst) begin
            to_r <= '0;
        end else begin
            to_r <= to_nxt_s;
        end
    end
`endif

    assign mode     = mode_r;
    assign blink_on = blink_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: directed scenarios then random key/tick traffic.
module tb_time_set_ctrl;

    localparam int TB_TO = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_press_short = 1'b0;
    logic       key_press_long = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink_on;

    int tests = 0;
    int failed = 0;

    typedef struct {
        int h; int m; int s; int md; int bl;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    int mh = 0, mm = 0, ms = 0, mmode = 0, mblink = 1, mto = 0;

    time_set_ctrl #(.HOUR_MAX(23), .MIN_MAX(59), .TIMEOUT_S(TB_TO)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .key_press_short(key_press_short), .key_press_long(key_press_long),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .mode(mode), .blink_on(blink_on)
    );

    always #5 clk = ~clk;

    task automatic model_tick_idle();
`ifdef SET_TIMEOUT_EN
        mto = mto + 1;
        if (mto >= TB_TO) begin
            mto = 0; mmode = 0; mblink = 1;
        end
`endif
    endtask

    task automatic model_step(input bit r, input bit t, input bit sh, input bit lg);
        int tot;
        if (r) begin
            mh = 0; mm = 0; ms = 0; mmode = 0; mblink = 1; mto = 0;
        end else if (mmode == 0) begin
            if (t) begin
                tot = (mh * 3600 + mm * 60 + ms + 1) % 86400;
                mh = tot / 3600; mm = (tot / 60) % 60; ms = tot % 60;
            end
            mblink = 1; mto = 0;
            if (lg) mmode = 1;
        end else begin
            if (lg) begin
                if (mmode == 2) ms = 0;
                mmode = (mmode == 1) ? 2 : 0;
                mblink = 1; mto = 0;
            end else if (sh) begin
                if (mmode == 1) mh = (mh + 1) % 24;
                else            mm = (mm + 1) % 60;
                mblink = 1; mto = 0;
            end else if (t) begin
                mblink = 1 - mblink;
                model_tick_idle();
            end
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs
    task automatic step(input bit r, input bit t, input bit sh, input bit lg);
        exp_t e;
        @(negedge clk);
        rst = r; tick_1hz = t; key_press_short = sh; key_press_long = lg;
        model_step(r, t, sh, lg);
        e.h = mh; e.m = mm; e.s = ms; e.md = mmode; e.bl = mblink;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input int h, input int m, input int s, input int md);
        @(posedge clk);
        #2;
        tests++;
        if (hours !== h[4:0] || minutes !== m[5:0] || seconds !== s[5:0] || mode !== md[1:0]) begin
            failed++;
            $display("FAIL %s: got %0d:%0d:%0d mode=%0d, want %0d:%0d:%0d mode=%0d",
                     name, hours, minutes, seconds, mode, h, m, s, md);
        end
    endtask

    // Monitor: every clock edge pops one expected response and compares
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (hours !== e.h[4:0] || minutes !== e.m[5:0] || seconds !== e.s[5:0] ||
                mode !== e.md[1:0] || blink_on !== e.bl[0]) begin
                failed++;
                $display("FAIL cycle t=%0t: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                         $time, hours, minutes, seconds, mode, blink_on,
                         e.h, e.m, e.s, e.md, e.bl);
            end
        end
    end

    initial begin
        // reset state
        step(1, 0, 0, 0);
        check_now("reset", 0, 0, 0, 0);

        // set sequence with frozen seconds
        step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        check_now("set_seq", 5, 12, 0, 0);

        // reset mid-set with minutes=37
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        for (int i = 0; i < 25; i++) step(0, 0, 1, 0);
        check_now("min37", 5, 37, 0, 2);
        step(1, 1, 1, 1);
        check_now("reset_mid_set", 0, 0, 0, 0);

        // preload 23:59 via wraps, then ticks to 23:59:59 and the full carry
        step(0, 0, 0, 1);
        for (int i = 0; i < 23; i++) step(0, 0, 1, 0);
        check_now("hour23", 23, 0, 0, 1);
        step(0, 0, 1, 0);
        check_now("hour_wrap", 0, 0, 0, 1);
        for (int i = 0; i < 23; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 0);
        check_now("min59", 23, 59, 0, 2);
        step(0, 0, 1, 0);
        check_now("min_wrap_no_carry", 23, 0, 0, 2);
        for (int i = 0; i < 59; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
        check_now("235959", 23, 59, 59, 0);
        step(0, 1, 0, 0);
        check_now("carry_chain", 0, 0, 0, 0);

        // short+long together in SET_HOUR: long wins
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        check_now("short_long", 1, 0, 0, 2);

        // tick + long in RUN at 10:00:07
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        check_now("tick_long", 10, 0, 8, 1);

        // idle ticks in SET_HOUR, with a short press on the 2nd tick
        step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
`ifdef SET_TIMEOUT_EN
        check_now("restart_count", 11, 0, 8, 1);
        step(0, 1, 0, 0);
        check_now("timeout", 11, 0, 8, 0);
`else
        step(0, 1, 0, 0);
        check_now("no_timeout", 11, 0, 8, 1);
`endif

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 300) == 0, ($urandom % 3) == 0,
                 ($urandom % 4) == 0, ($urandom % 25) == 0);
        end
        step(0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
